// File: rtl/bank_mmu_if.sv
// Processor-side bus of the banked MMU: memory/I-O strobes, address and the
// mapped page, write-enable and status outputs toward the memory board.
interface bank_mmu_if #(
  parameter int AEXT_W = 8
);
  logic              nmem;
  logic              nio;
  logic              nr;
  logic              nw;
  logic              nfpram;
  logic [15:0]       ab;
  logic [AEXT_W-1:0] aext;
  logic              nwe_mem;
  logic              banking;
  logic              fault;

  modport master (
    output nmem, nio, nr, nw, nfpram, ab,
    input  aext, nwe_mem, banking, fault
  );

  modport slave (
    input  nmem, nio, nr, nw, nfpram, ab,
    output aext, nwe_mem, banking, fault
  );
endinterface

// File: rtl/bank_mmu.sv
// Banked memory management unit: maps the 16-bit logical bus onto a physical
// page via I/O-writable bank registers, with boot map and write protection.
module bank_mmu #(
  parameter int                NBANKS   = 8,
  parameter int                AEXT_W   = 8,
  parameter logic [15:0]       IO_BASE  = 16'h20,
  parameter logic [AEXT_W-1:0] ROM_BASE = AEXT_W'(8'h80)
) (
  input  logic        clock,
  input  logic        nreset,
  bank_mmu_if.slave   bus,
  inout  wire  [15:0] db
);
  localparam int          LB         = $clog2(NBANKS);
  localparam logic [15:0] STAT_ADDR  = IO_BASE + 16'(NBANKS);
  localparam logic [15:0] FADDR_ADDR = STAT_ADDR + 16'd1;

  logic [AEXT_W-1:0] page [NBANKS];
  logic [NBANKS-1:0] wp;
  logic              banking;
  logic              fault;
  logic [15:0]       fault_addr;

  logic [LB-1:0]     idx;
  logic [LB-1:0]     ridx;
  logic              bank_hit;
  logic              stat_hit;
  logic              faddr_hit;
  logic              io_wr;
  logic              io_rd;
  logic              fault_clr;
  logic              blocked;
  logic [15:0]       rd_data;
  logic [AEXT_W-1:0] aext;
  logic              unused_db;

  assign idx  = bus.ab[15 -: LB];
  assign ridx = bus.ab[LB-1:0];

  // IO_BASE is aligned to 2*NBANKS, so bit LB is 0 for every bank register
  assign bank_hit  = (bus.ab[15:LB] == IO_BASE[15:LB]);
  assign stat_hit  = (bus.ab == STAT_ADDR);
  assign faddr_hit = (bus.ab == FADDR_ADDR);

  assign io_wr     = !bus.nio && !bus.nw;
  assign io_rd     = !bus.nio && !bus.nr;
  assign fault_clr = io_wr && stat_hit && db[0];

  // I/O cycles take precedence, so an overlapping memory write is never seen
  assign blocked = banking && bus.nio && !bus.nmem && !bus.nw && wp[idx];

  assign unused_db = ^db[14:AEXT_W];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < unsigned'(NBANKS); i++) begin
        page[i] <= '0;
      end
      wp         <= '0;
      banking    <= 1'b0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      if (io_wr && bank_hit) begin
        page[ridx] <= db[AEXT_W-1:0];
        wp[ridx]   <= db[15];
        if (ridx[LB-1]) begin
          banking <= 1'b1;
        end
      end
      // A concurrent clear re-arms capture, so the new address is recorded
      if (blocked) begin
        fault <= 1'b1;
        if (!fault || fault_clr) begin
          fault_addr <= bus.ab;
        end
      end else if (fault_clr) begin
        fault <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (bank_hit) begin
      rd_data[15]         = wp[ridx];
      rd_data[AEXT_W-1:0] = page[ridx];
    end else if (stat_hit) begin
      rd_data[1:0] = {fault, banking};
    end else if (faddr_hit) begin
      rd_data = fault_addr;
    end
  end

  assign db = (io_rd && (bank_hit || stat_hit || faddr_hit)) ? rd_data : 'z;

  always_comb begin
    aext = '0;
    if (banking) begin
      aext = page[idx];
    end else if (!idx[LB-1] || !bus.nfpram) begin
      aext = AEXT_W'(idx);
    end else begin
      aext = ROM_BASE + AEXT_W'(idx) - AEXT_W'(NBANKS / 2);
    end
  end

  assign bus.aext    = aext;
  assign bus.nwe_mem = !bus.nio || blocked || bus.nw || bus.nmem;
  assign bus.banking = banking;
  assign bus.fault   = fault;
endmodule

// File: tb/tb_bank_mmu.sv
// Directed bench for bank_mmu: vector tables for the 8- and 16-bank builds,
// plus hand-written sequences for bus overlap and mid-write reset.
module tb_bank_mmu;
  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        nmem = 1'b1, nio = 1'b1, nr = 1'b1, nw = 1'b1, nfpram = 1'b1;
  logic [15:0] ab = '0;
  logic [15:0] db_out = '0;
  logic        db_oe = 1'b0;
  wire  [15:0] db8;
  wire  [15:0] db16;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clock = ~clock;

  bank_mmu_if #(.AEXT_W(8)) if8 ();
  bank_mmu_if #(.AEXT_W(8)) if16 ();

  assign if8.nmem  = nmem;  assign if8.nio  = nio;  assign if8.nr  = nr;
  assign if8.nw    = nw;    assign if8.nfpram = nfpram; assign if8.ab = ab;
  assign if16.nmem = nmem;  assign if16.nio = nio;  assign if16.nr = nr;
  assign if16.nw   = nw;    assign if16.nfpram = nfpram; assign if16.ab = ab;

  assign db8  = db_oe ? db_out : 'z;
  assign db16 = db_oe ? db_out : 'z;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (db8[g]);
    pullup (db16[g]);
  end

  bank_mmu #(.NBANKS(8), .AEXT_W(8), .IO_BASE(16'h20), .ROM_BASE(8'h80)) u_mmu8 (
    .clock (clock), .nreset (nreset), .bus (if8), .db (db8)
  );

  bank_mmu #(.NBANKS(16), .AEXT_W(8), .IO_BASE(16'h20), .ROM_BASE(8'h80)) u_mmu16 (
    .clock (clock), .nreset (nreset), .bus (if16), .db (db16)
  );

  typedef enum logic [2:0] {OP_RST, OP_MEMRD, OP_MEMWR, OP_IOWR, OP_IORD} op_e;

  typedef struct {
    op_e         op;
    logic [15:0] ab;
    logic [15:0] data;
    logic        nfp;
    logic [15:0] exp;
    logic        exp_bank;
    logic        exp_nwe;
    logic        exp_flt;
  } vec_t;

  vec_t ta[$];
  vec_t tb[$];
  vec_t tc[$];

  function automatic vec_t rs();
    return '{OP_RST, 16'h0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0};
  endfunction
  function automatic vec_t mr(logic [15:0] a, logic f, logic [7:0] e, logic b);
    return '{OP_MEMRD, a, 16'h0, f, {8'h0, e}, b, 1'b1, 1'b0};
  endfunction
  function automatic vec_t mw(logic [15:0] a, logic [7:0] e, logic n, logic fl);
    return '{OP_MEMWR, a, 16'h0, 1'b0, {8'h0, e}, 1'b1, n, fl};
  endfunction
  function automatic vec_t iw(logic [15:0] a, logic [15:0] d, logic b);
    return '{OP_IOWR, a, d, 1'b0, 16'h0, b, 1'b1, 1'b0};
  endfunction
  function automatic vec_t ir(logic [15:0] a, logic [15:0] e);
    return '{OP_IORD, a, 16'h0, 1'b0, e, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [7:0] get_aext(bit s);
    return s ? if16.aext : if8.aext;
  endfunction
  function automatic logic get_bank(bit s);
    return s ? if16.banking : if8.banking;
  endfunction
  function automatic logic get_flt(bit s);
    return s ? if16.fault : if8.fault;
  endfunction
  function automatic logic get_nwe(bit s);
    return s ? if16.nwe_mem : if8.nwe_mem;
  endfunction
  function automatic logic [15:0] get_db(bit s);
    return s ? db16 : db8;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    nmem = 1'b1; nio = 1'b1; nr = 1'b1; nw = 1'b1; db_oe = 1'b0;
  endtask

  task automatic run_vec(input string nm, input bit s, input vec_t v);
    @(negedge clock);
    ab = v.ab;
    case (v.op)
      OP_RST: begin
        idle();
        nfpram = 1'b1;
        nreset = 1'b0;
        @(posedge clock); #1;
        chk({nm, ".rst_bank"}, 16'(get_bank(s)), 16'h0);
        chk({nm, ".rst_fault"}, 16'(get_flt(s)), 16'h0);
        chk({nm, ".rst_nwe"}, 16'(get_nwe(s)), 16'h1);
        @(negedge clock);
        nreset = 1'b1;
      end
      OP_MEMRD: begin
        nfpram = v.nfp; nmem = 1'b0; nr = 1'b0;
        #1;
        chk({nm, ".aext"}, 16'(get_aext(s)), v.exp);
        chk({nm, ".bank"}, 16'(get_bank(s)), 16'(v.exp_bank));
        @(posedge clock); #1;
        idle();
      end
      OP_MEMWR: begin
        nmem = 1'b0; nw = 1'b0;
        #1;
        chk({nm, ".aext"}, 16'(get_aext(s)), v.exp);
        chk({nm, ".nwe"}, 16'(get_nwe(s)), 16'(v.exp_nwe));
        @(posedge clock); #1;
        chk({nm, ".fault"}, 16'(get_flt(s)), 16'(v.exp_flt));
        idle();
      end
      OP_IOWR: begin
        nio = 1'b0; nw = 1'b0; db_oe = 1'b1; db_out = v.data;
        @(posedge clock); #1;
        idle();
        chk({nm, ".bank"}, 16'(get_bank(s)), 16'(v.exp_bank));
      end
      OP_IORD: begin
        nio = 1'b0; nr = 1'b0;
        #1;
        chk({nm, ".db"}, get_db(s), v.exp);
        @(posedge clock); #1;
        idle();
        #1;
        chk({nm, ".db_idle"}, get_db(s), 16'hFFFF);
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // 8-bank build: boot map, banking enable, readback, protection, fault clear
    ta.push_back(rs());
    ta.push_back(mr(16'h2000, 1'b1, 8'h01, 1'b0));
    ta.push_back(mr(16'hFFF0, 1'b1, 8'h83, 1'b0));
    ta.push_back(mr(16'h8000, 1'b1, 8'h80, 1'b0));
    ta.push_back(mr(16'h6000, 1'b1, 8'h03, 1'b0));
    ta.push_back(mr(16'hE000, 1'b0, 8'h07, 1'b0));
    ta.push_back(iw(16'h0022, 16'h0005, 1'b0));
    ta.push_back(mr(16'h4000, 1'b0, 8'h02, 1'b0));
    ta.push_back(iw(16'h0027, 16'h0091, 1'b1));
    ta.push_back(mr(16'hE000, 1'b0, 8'h91, 1'b1));
    ta.push_back(mr(16'h4000, 1'b0, 8'h05, 1'b1));
    ta.push_back(mr(16'h0000, 1'b0, 8'h00, 1'b1));
    ta.push_back(ir(16'h0027, 16'h0091));
    ta.push_back(ir(16'h0028, 16'h0001));
    ta.push_back(ir(16'h0022, 16'h0005));
    ta.push_back(ir(16'h002A, 16'hFFFF));
    ta.push_back(iw(16'h0023, 16'h8010, 1'b1));
    ta.push_back(ir(16'h0023, 16'h8010));
    ta.push_back(mw(16'h6123, 8'h10, 1'b1, 1'b1));
    ta.push_back(ir(16'h0029, 16'h6123));
    ta.push_back(ir(16'h0028, 16'h0003));
    ta.push_back(mw(16'h6200, 8'h10, 1'b1, 1'b1));
    ta.push_back(ir(16'h0029, 16'h6123));
    ta.push_back(iw(16'h0028, 16'h0000, 1'b1));
    ta.push_back(ir(16'h0028, 16'h0003));
    ta.push_back(iw(16'h0028, 16'h0001, 1'b1));
    ta.push_back(ir(16'h0028, 16'h0001));
    ta.push_back(mw(16'h4000, 8'h05, 1'b0, 1'b0));
    ta.push_back(ir(16'h0029, 16'h6123));
    ta.push_back(mw(16'h6300, 8'h10, 1'b1, 1'b1));
    ta.push_back(ir(16'h0029, 16'h6300));

    // after a reset that interrupted an I/O write
    tc.push_back(ir(16'h0024, 16'h0000));
    tc.push_back(ir(16'h0027, 16'h0000));
    tc.push_back(ir(16'h0029, 16'h0000));
    tc.push_back(ir(16'h0028, 16'h0000));
    tc.push_back(mr(16'hFFF0, 1'b1, 8'h83, 1'b0));

    // 16-bank build
    tb.push_back(rs());
    tb.push_back(mr(16'h2000, 1'b1, 8'h02, 1'b0));
    tb.push_back(mr(16'hFFF0, 1'b1, 8'h87, 1'b0));
    tb.push_back(mr(16'h8000, 1'b1, 8'h80, 1'b0));
    tb.push_back(mr(16'hE000, 1'b0, 8'h0E, 1'b0));
    tb.push_back(iw(16'h0022, 16'h0005, 1'b0));
    tb.push_back(iw(16'h0027, 16'h0044, 1'b0));
    tb.push_back(iw(16'h002E, 16'h0091, 1'b1));
    tb.push_back(mr(16'hE000, 1'b0, 8'h91, 1'b1));
    tb.push_back(mr(16'h2000, 1'b0, 8'h05, 1'b1));
    tb.push_back(mr(16'h7000, 1'b0, 8'h44, 1'b1));
    tb.push_back(ir(16'h0030, 16'h0001));
    tb.push_back(ir(16'h002E, 16'h0091));
    tb.push_back(ir(16'h0028, 16'h0000));

    idle();
    repeat (2) @(posedge clock);

    foreach (ta[i]) run_vec($sformatf("a%0d", i), 1'b0, ta[i]);

    // overlapping memory and I/O cycle: I/O wins, memory write suppressed
    @(negedge clock);
    ab = 16'h002A; nmem = 1'b0; nio = 1'b0; nw = 1'b0;
    #1;
    chk("overlap.nwe", 16'(if8.nwe_mem), 16'h1);
    @(posedge clock); #1;
    idle();

    // reset asserted in the middle of a bank-register write
    @(negedge clock);
    ab = 16'h0024; nio = 1'b0; nw = 1'b0; db_oe = 1'b1; db_out = 16'h00AB;
    #2 nreset = 1'b0;
    #1;
    chk("midrst.bank", 16'(if8.banking), 16'h0);
    chk("midrst.fault", 16'(if8.fault), 16'h0);
    @(posedge clock); #1;
    idle();
    @(negedge clock);
    nreset = 1'b1;

    foreach (tc[i]) run_vec($sformatf("c%0d", i), 1'b0, tc[i]);
    foreach (tb[i]) run_vec($sformatf("b%0d", i), 1'b1, tb[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
